// File: rtl/booth_mult_seq_if.sv
// Handshake and operand/result bundle for the sequential Booth multiplier.
// The master drives the request and operands; the slave returns status and product.
interface booth_mult_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, is_signed, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, is_signed, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one add/sub/none decision plus an arithmetic
// right shift of {A,Q,q-1} per cycle; signed mode runs WIDTH steps, unsigned WIDTH+1.
module booth_mult_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    booth_mult_seq_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 2);

    typedef enum logic {IDLE, CALC} state_t;

    state_t             state;
    logic [WIDTH+1:0]   a;
    logic [WIDTH+1:0]   m;
    logic [WIDTH:0]     q;
    logic               q_1;
    logic               sgn;
    logic [CW-1:0]      count;

    logic [WIDTH:0]     ext_mcand;
    logic [WIDTH:0]     ext_mplier;
    logic [WIDTH+1:0]   sum;
    logic [2*WIDTH+3:0] sh;
    logic [2*WIDTH-1:0] result;

    always_comb begin
        ext_mcand  = bus.is_signed ? {bus.multiplicand[WIDTH-1], bus.multiplicand}
                                   : {1'b0, bus.multiplicand};
        ext_mplier = bus.is_signed ? {bus.multiplier[WIDTH-1], bus.multiplier}
                                   : {1'b0, bus.multiplier};
    end

    always_comb begin
        sum = a;
        case ({q[0], q_1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
    end

    // sh = {A,Q,q-1} after the arithmetic shift, so {A,Q} is sh[2W+3:1].
    // Signed mode leaves the unprocessed sign bit of Q in bit 0 of {A,Q},
    // so the exact product sits one place higher than in unsigned mode.
    assign sh     = {sum[WIDTH+1], sum, q};
    assign result = sgn ? sh[2*WIDTH+1:2] : sh[2*WIDTH:1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            a           <= '0;
            m           <= '0;
            q           <= '0;
            q_1         <= 1'b0;
            sgn         <= 1'b0;
            count       <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.product <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a        <= '0;
                        m        <= {ext_mcand[WIDTH], ext_mcand};
                        q        <= ext_mplier;
                        q_1      <= 1'b0;
                        sgn      <= bus.is_signed;
                        count    <= bus.is_signed ? CW'(WIDTH) : CW'(WIDTH + 1);
                        bus.busy <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    a     <= sh[2*WIDTH+3:WIDTH+2];
                    q     <= sh[WIDTH+1:1];
                    q_1   <= sh[0];
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        bus.product <= result;
                        bus.done    <= 1'b1;
                        bus.busy    <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mult_seq.sv
// Randomised bench for booth_mult_seq: a cycle-level behavioural model (countdown plus
// plain integer multiply) is compared against busy/done/product on every cycle.
module tb_booth_mult_seq;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    booth_mult_seq_if #(.WIDTH(W)) bus();

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    function automatic logic [31:0] mul(input logic [15:0] x, input logic [15:0] y, input logic s);
        longint xa, ya, p;
        if (s) begin
            xa = longint'($signed(x));
            ya = longint'($signed(y));
        end else begin
            xa = longint'(x);
            ya = longint'(y);
        end
        p = xa * ya;
        return p[31:0];
    endfunction

    function automatic int iters(input logic s);
        return s ? 16 : 17;
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h7FFF;
            4: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted request yields a*b exactly N edges later.
    int          m_rem;
    logic        m_busy, m_done;
    logic [31:0] m_prod, m_res;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_prod <= '0;
            m_res  <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_prod <= m_res;
                end
            end else if (bus.start) begin
                m_rem  <= iters(bus.is_signed);
                m_busy <= 1'b1;
                m_res  <= mul(bus.multiplicand, bus.multiplier, bus.is_signed);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check32("busy", 32'(bus.busy), 32'(m_busy));
            check32("done", 32'(bus.done), 32'(m_done));
            check32("product", bus.product, m_prod);
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic launch(input logic [15:0] x, input logic [15:0] y, input logic s);
        bus.multiplicand = x;
        bus.multiplier   = y;
        bus.is_signed    = s;
        bus.start        = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int lat0, output int lat, output int bcnt, output logic [31:0] p);
        lat  = lat0;
        bcnt = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) break;
            if (bus.busy) bcnt++;
        end
        if (!bus.done) begin
            errors++;
            $display("FAIL timeout waiting for done at %0t", $time);
        end
        p = bus.product;
    endtask

    task automatic run(input logic [15:0] x, input logic [15:0] y, input logic s, output logic [31:0] p);
        int lat, bcnt;
        launch(x, y, s);
        wait_done(0, lat, bcnt, p);
        check32("result", p, mul(x, y, s));
        check32("latency", 32'(lat), 32'(iters(s)));
        check32("busy_cycles", 32'(bcnt), 32'(iters(s)));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        int lat, bcnt;
        logic [15:0] x, y;
        logic s;

        bus.start        = 1'b0;
        bus.is_signed    = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        rst_n            = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        check32("reset_busy", 32'(bus.busy), 32'h0);
        check32("reset_done", 32'(bus.done), 32'h0);
        check32("reset_product", bus.product, 32'h0);

        // Literal expectations pinning both the DUT and the model.
        check32("model_pin_neg21", mul(16'd7, 16'hFFFD, 1'b1), 32'hFFFF_FFEB);
        run(16'd7, 16'hFFFD, 1'b1, p);
        check32("t1_signed", p, 32'hFFFF_FFEB);
        run(16'h8000, 16'h8000, 1'b1, p);
        check32("t2_min_signed", p, 32'h4000_0000);
        run(16'h8000, 16'h8000, 1'b0, p);
        check32("t2_min_unsigned", p, 32'h4000_0000);
        run(16'hFFFF, 16'hFFFF, 1'b0, p);
        check32("t3_max_unsigned", p, 32'hFFFE_0001);
        run(16'hFFFF, 16'hFFFF, 1'b1, p);
        check32("t3_neg1_signed", p, 32'h0000_0001);

        // Start pulsed while busy must be ignored.
        launch(16'h1234, 16'h0567, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.multiplicand = 16'd2;
        bus.multiplier   = 16'd3;
        bus.is_signed    = 1'b1;
        bus.start        = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(4, lat, bcnt, p);
        check32("t4_first_result", p, 32'(32'h1234 * 32'h0567));
        check32("t4_first_latency", 32'(lat), 32'd17);
        check32("t4_done_at_restart", 32'(bus.done), 32'h1);
        run(16'd2, 16'd3, 1'b1, p);
        check32("t4_back_to_back", p, 32'd6);

        // Reset in the middle of an operation.
        launch(16'hFFFB, 16'd1234, 1'b1);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check32("t5_busy", 32'(bus.busy), 32'h0);
        check32("t5_done", 32'(bus.done), 32'h0);
        check32("t5_product", bus.product, 32'h0);
        run(16'h7FFF, 16'h8001, 1'b1, p);
        check32("t5_after_reset", p, 32'hC000_FFFF);

        // Random mix, mostly back-to-back from the done cycle.
        for (int i = 0; i < 2000; i++) begin
            x = pick();
            y = pick();
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            run(x, y, s, p);
        end

        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
